// File: rtl/malu_arbiter.sv
// Round-robin arbiter/sequencer that shares one mALUma ALU between two requesters.
// One job in flight at a time; a watchdog aborts jobs whose ALU never answers.
module malu_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_op_a,
  input  logic [63:0] req_op_b,
  input  logic [5:0]  req_op_code,
  input  logic [1:0]  req_mode_fp,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        alu_rst,
  output logic        alu_start,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  output logic [2:0]  alu_op_code,
  output logic        alu_mode_fp,
  input  logic        alu_valid_out,
  input  logic [31:0] alu_result,
  input  logic [4:0]  alu_flags,
  output logic [1:0]  grant,
  output logic        busy
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("malu_arbiter: TIMEOUT must be within 1..65535");
  end

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FLUSH = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Handshake: a job moves on the edge where req_valid[i] && req_ready[i];
  // the requester holds valid and operands stable until then.
  state_t      state;
  state_t      state_next;
  logic        prio;
  logic [15:0] wd_cnt;
  logic [1:0]  win_oh;
  logic        win_idx;
  logic        accept;

  // Requester prio wins a tie; the other one only gets in when prio is idle.
  always_comb begin
    win_oh  = 2'b00;
    win_idx = prio;
    if (req_valid[prio]) begin
      win_idx      = prio;
      win_oh[prio] = 1'b1;
    end else if (req_valid[~prio]) begin
      win_idx       = ~prio;
      win_oh[~prio] = 1'b1;
    end
  end

  assign req_ready = (state == S_IDLE && !rst) ? win_oh : 2'b00;
  assign accept    = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        // A result arriving on the limit cycle still beats the abort.
        if (alu_valid_out) begin
          state_next = S_RESP;
        end else if (wd_cnt == TIMEOUT_W) begin
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_start = (state == S_ISSUE);
    busy      = (state != S_IDLE);
    rsp_valid = (state == S_RESP) ? grant : 2'b00;
    alu_rst   = rst || (state == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= 1'b0;
      wd_cnt      <= 16'd0;
      grant       <= 2'b00;
      alu_op_a    <= 32'd0;
      alu_op_b    <= 32'd0;
      alu_op_code <= 3'd0;
      alu_mode_fp <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_flags   <= 5'd0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_op_a    <= win_idx ? req_op_a[63:32]   : req_op_a[31:0];
            alu_op_b    <= win_idx ? req_op_b[63:32]   : req_op_b[31:0];
            alu_op_code <= win_idx ? req_op_code[5:3]  : req_op_code[2:0];
            alu_mode_fp <= win_idx ? req_mode_fp[1]    : req_mode_fp[0];
            grant       <= win_oh;
          end
        end
        S_ISSUE: wd_cnt <= 16'd0;
        S_WAIT: begin
          if (alu_valid_out) begin
            rsp_result  <= alu_result;
            rsp_flags   <= alu_flags;
            rsp_timeout <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_FLUSH: begin
          rsp_result  <= 32'd0;
          rsp_flags   <= 5'd0;
          rsp_timeout <= 1'b1;
        end
        S_RESP: begin
          // Hand priority to whoever was not just served.
          prio  <= grant[0];
          grant <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_malu_arbiter.sv
// Directed bench for malu_arbiter: a table of jobs with hand-computed responses,
// followed by spurious-valid and reset-during-WAIT sequences.
module tb_malu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_op_a;
  logic [63:0] req_op_b;
  logic [5:0]  req_op_code;
  logic [1:0]  req_mode_fp;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_timeout;
  logic        alu_rst;
  logic        alu_start;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [2:0]  alu_op_code;
  logic        alu_mode_fp;
  logic        alu_valid_out;
  logic [31:0] alu_result;
  logic [4:0]  alu_flags;
  logic [1:0]  grant;
  logic        busy;

  malu_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_op_code(req_op_code), .req_mode_fp(req_mode_fp),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .alu_rst(alu_rst), .alu_start(alu_start),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_op_code(alu_op_code), .alu_mode_fp(alu_mode_fp),
    .alu_valid_out(alu_valid_out), .alu_result(alu_result),
    .alu_flags(alu_flags), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  c0, c1;
    logic [1:0]  fp;
    int          lat;    // cycles from alu_start to alu_valid_out
    bit          never;  // ALU never answers
    logic [31:0] ares;
    logic [4:0]  aflg;
    int          win;
    logic [31:0] eres;
    logic [4:0]  eflg;
    bit          eto;
    int          rcyc;   // cycle of rsp_valid, counting the ISSUE cycle as 1
    int          nrst;   // expected alu_rst pulses
  } job_t;

  job_t tbl[12];
  int tests = 0;
  int fails = 0;
  logic [31:0] last_res;
  logic [4:0]  last_flg;
  logic        last_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  // Called just after a negedge with the arbiter in IDLE; returns just after the
  // negedge of the IDLE cycle following the response.
  task automatic run_job(input int idx, input job_t j);
    bit got;
    bit done;
    int r;
    int start_cnt;
    int rst_cnt;
    req_op_a    = {j.a1, j.a0};
    req_op_b    = {j.b1, j.b0};
    req_op_code = {j.c1, j.c0};
    req_mode_fp = j.fp;
    req_valid   = j.mask;
    #1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready != 2'b00) begin
        got = 1;
        break;
      end
      @(negedge clk); #1;
    end
    chk($sformatf("r%0d_ready_seen", idx), got, 1);
    if (!got) begin
      req_valid = 2'b00;
      return;
    end
    chk($sformatf("r%0d_ready_winner", idx), req_ready, oh(j.win));
    @(negedge clk);
    req_valid = req_valid & ~oh(j.win);
    chk($sformatf("r%0d_issue_grant", idx), grant, oh(j.win));
    chk($sformatf("r%0d_issue_busy", idx), busy, 1);
    chk($sformatf("r%0d_op_a", idx), alu_op_a, (j.win == 1) ? j.a1 : j.a0);
    chk($sformatf("r%0d_op_b", idx), alu_op_b, (j.win == 1) ? j.b1 : j.b0);
    chk($sformatf("r%0d_op_code", idx), alu_op_code, (j.win == 1) ? j.c1 : j.c0);
    chk($sformatf("r%0d_mode_fp", idx), alu_mode_fp, (j.win == 1) ? j.fp[1] : j.fp[0]);
    r = 0;
    done = 0;
    start_cnt = 0;
    rst_cnt = 0;
    alu_result = j.ares;
    alu_flags  = j.aflg;
    for (int c = 1; c < 300; c++) begin
      start_cnt += int'(alu_start);
      rst_cnt   += int'(alu_rst);
      if (rsp_valid != 2'b00) begin
        r = c;
        done = 1;
        break;
      end
      alu_valid_out = !j.never && (c == 1 + j.lat);
      @(negedge clk);
    end
    alu_valid_out = 1'b0;
    chk($sformatf("r%0d_rsp_seen", idx), done, 1);
    chk($sformatf("r%0d_rsp_cycle", idx), r, j.rcyc);
    chk($sformatf("r%0d_rsp_valid", idx), rsp_valid, oh(j.win));
    chk($sformatf("r%0d_rsp_result", idx), rsp_result, j.eres);
    chk($sformatf("r%0d_rsp_flags", idx), rsp_flags, j.eflg);
    chk($sformatf("r%0d_rsp_timeout", idx), rsp_timeout, j.eto);
    chk($sformatf("r%0d_start_pulses", idx), start_cnt, 1);
    chk($sformatf("r%0d_alu_rst_pulses", idx), rst_cnt, j.nrst);
    @(negedge clk);
    chk($sformatf("r%0d_rsp_valid_drop", idx), rsp_valid, 2'b00);
    chk($sformatf("r%0d_idle_busy", idx), busy, 0);
    chk($sformatf("r%0d_idle_grant", idx), grant, 2'b00);
    chk($sformatf("r%0d_rsp_held", idx), rsp_result, j.eres);
    last_res = j.eres;
    last_flg = j.eflg;
    last_to  = j.eto;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "global timeout");
  end

  initial begin
    //        mask   a0            b0            a1            b1            c0    c1    fp     lat nv ares          aflg   win eres          eflg   eto rcyc nrst
    tbl[0]  = '{2'b01, 32'h5,        32'h3,        32'h0,        32'h0,        3'd0, 3'd0, 2'b00, 3,  0, 32'h8,        5'h00, 0, 32'h8,        5'h00, 0, 5,  0};
    tbl[1]  = '{2'b10, 32'h0,        32'h0,        32'h10,       32'h20,       3'd0, 3'd3, 2'b10, 1,  0, 32'h30,       5'h12, 1, 32'h30,       5'h12, 0, 3,  0};
    tbl[2]  = '{2'b11, 32'h1111_0000, 32'h111,     32'h2222_0000, 32'h222,     3'd1, 3'd2, 2'b01, 2,  0, 32'h0111_1111, 5'h01, 0, 32'h0111_1111, 5'h01, 0, 4,  0};
    tbl[3]  = '{2'b11, 32'h1111_0000, 32'h111,     32'h2222_0000, 32'h222,     3'd1, 3'd2, 2'b01, 4,  0, 32'h0222_2222, 5'h02, 1, 32'h0222_2222, 5'h02, 0, 6,  0};
    tbl[4]  = '{2'b11, 32'hA0,       32'hB0,       32'hA1,       32'hB1,       3'd5, 3'd6, 2'b10, 1,  0, 32'hF0,       5'h04, 0, 32'hF0,       5'h04, 0, 3,  0};
    tbl[5]  = '{2'b11, 32'hA0,       32'hB0,       32'hA1,       32'hB1,       3'd5, 3'd6, 2'b10, 2,  0, 32'hF1,       5'h08, 1, 32'hF1,       5'h08, 0, 4,  0};
    tbl[6]  = '{2'b01, 32'h7,        32'h9,        32'h0,        32'h0,        3'd4, 3'd0, 2'b01, 0,  1, 32'hAAAA_5555, 5'h1F, 0, 32'h0,        5'h00, 1, 12, 1};
    tbl[7]  = '{2'b10, 32'h0,        32'h0,        32'h100,      32'h200,      3'd0, 3'd7, 2'b00, 3,  0, 32'h300,      5'h00, 1, 32'h300,      5'h00, 0, 5,  0};
    tbl[8]  = '{2'b01, 32'h1234,     32'h5678,     32'h0,        32'h0,        3'd2, 3'd0, 2'b00, 9,  0, 32'h1234_5678, 5'h1F, 0, 32'h1234_5678, 5'h1F, 0, 11, 0};
    tbl[9]  = '{2'b10, 32'h0,        32'h0,        32'h1,        32'h2,        3'd0, 3'd1, 2'b10, 10, 0, 32'hCAFE,     5'h05, 1, 32'h0,        5'h00, 1, 12, 1};
    tbl[10] = '{2'b01, 32'h50,       32'h5,        32'h0,        32'h0,        3'd3, 3'd0, 2'b00, 2,  0, 32'h55,       5'h03, 0, 32'h55,       5'h03, 0, 4,  0};
    tbl[11] = '{2'b11, 32'hC0,       32'hC1,       32'hD0,       32'hD1,       3'd2, 3'd3, 2'b11, 1,  0, 32'h77,       5'h06, 0, 32'h77,       5'h06, 0, 3,  0};

    rst = 1'b1;
    req_valid = 2'b00;
    req_op_a = '0;
    req_op_b = '0;
    req_op_code = '0;
    req_mode_fp = '0;
    alu_valid_out = 1'b0;
    alu_result = '0;
    alu_flags = '0;
    last_res = '0;
    last_flg = '0;
    last_to = 1'b0;

    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_alu_rst", alu_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant, 2'b00);
    chk("reset_alu_start", alu_start, 0);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp_result", rsp_result, 32'h0);
    chk("reset_rsp_flags", rsp_flags, 5'h0);
    chk("reset_rsp_timeout", rsp_timeout, 0);
    chk("reset_alu_op_a", alu_op_a, 32'h0);
    chk("reset_alu_op_b", alu_op_b, 32'h0);
    chk("reset_alu_op_code", alu_op_code, 3'h0);
    chk("reset_alu_mode_fp", alu_mode_fp, 0);
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_reset_alu_rst", alu_rst, 0);

    for (int i = 0; i <= 10; i++) begin
      run_job(i, tbl[i]);
    end
    req_valid = 2'b00;

    // ALU valid while IDLE must not disturb the held response.
    alu_valid_out = 1'b1;
    alu_result = 32'hDEAD_BEEF;
    alu_flags = 5'h1F;
    @(negedge clk);
    alu_valid_out = 1'b0;
    chk("spur_rsp_valid", rsp_valid, 2'b00);
    chk("spur_rsp_result", rsp_result, last_res);
    chk("spur_rsp_flags", rsp_flags, last_flg);
    chk("spur_rsp_timeout", rsp_timeout, last_to);
    chk("spur_busy", busy, 0);
    @(negedge clk);
    chk("spur_rsp_valid_late", rsp_valid, 2'b00);
    chk("spur_rsp_result_late", rsp_result, last_res);

    // Reset in the middle of WAIT, with priority currently on requester 1.
    req_op_a = {32'h0, 32'h99};
    req_op_b = {32'h0, 32'h98};
    req_op_code = 6'd1;
    req_mode_fp = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("rw_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("rw_issue_start", alu_start, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rw_wait_busy", busy, 1);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rw_alu_rst_in_reset", alu_rst, 1);
    chk("rw_ready_in_reset", req_ready, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_busy_after", busy, 0);
    chk("rw_grant_after", grant, 2'b00);
    chk("rw_rsp_valid_after", rsp_valid, 2'b00);
    chk("rw_alu_rst_after", alu_rst, 0);
    chk("rw_rsp_result_after", rsp_result, 32'h0);
    chk("rw_prio_reset_winner", req_ready, 2'b01);
    run_job(11, tbl[11]);
    req_valid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
